// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg: shared constants for the coprocessor-0 block.
//   CP0 register numbers, ExcCode values, exception vectors and
//   Status/Cause bit positions used by cp0_unit and cp0_timer.
//   No ports (package).
package cp0_unit_pkg;

    // CP0 register numbers (select 0)
    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [4:0] CP0_REG_PRID     = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13
    } exc_code_e;

    localparam logic [31:0] EXC_VEC_BOOT = 32'hBFC0_0380;
    localparam logic [31:0] EXC_VEC_NORM = 32'h8000_0180;

    // Status bits that are fixed at their reset value (CU0, BEV)
    localparam logic [31:0] STATUS_FIXED = 32'h1040_0000;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_BEV = 22;
    localparam int CAUSE_TI   = 30;
    localparam int CAUSE_BD   = 31;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with clock divider and sticky TI flag.
//   Only instantiated when CP0_TIMER_EN is defined.
// Ports:
//   clk, rst           clock, async active-high reset
//   count_we_i         mtc0 Count this cycle
//   compare_we_i       mtc0 Compare this cycle
//   data_i             mtc0 write data
//   count_o, compare_o current register values
//   ti_o               timer interrupt (sticky until Compare write)
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] data_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic [3:0]  div_q, div_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic        wrap;
    logic [31:0] count_inc;

    assign wrap      = (div_q == 4'(COUNT_DIV - 1));
    assign count_inc = count_q + 32'd1;

    always_comb begin
        div_d     = div_q + 4'd1;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_we_i) begin
            count_d = data_i;
            div_d   = 4'd0;
        end else if (wrap) begin
            div_d   = 4'd0;
            count_d = count_inc;
            // match is taken against the value Count is about to hold
            if (count_inc == compare_q) ti_d = 1'b1;
        end
        // a Compare write beats a same-cycle match
        if (compare_we_i) begin
            compare_d = data_i;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= 4'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor-0 register set, exception/ERET commit and
//   masked interrupt request.
//   Optional timer: define CP0_TIMER_EN to build Count/Compare/TI
//   (cp0_timer); otherwise Count/Compare read 0 and TI is 0.
// Ports:
//   clk, rst                     clock, async active-high reset
//   we_i, waddr_i, data_i        mtc0 write
//   raddr_i, data_o              mfc0 read (combinational, no bypass)
//   hw_int_i                     level hardware interrupts
//   exc_valid_i, exc_code_i,
//   exc_pc_i, exc_bd_i,
//   exc_badvaddr_i               committed exception
//   eret_i                       committed ERET
//   status_o, cause_o, epc_o     live register values
//   int_req_o                    enabled interrupt pending
//   flush_o, redirect_pc_o       same-cycle pipeline redirect
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [4:0]            raddr_i,
    input  logic [31:0]           data_i,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic                  eret_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic [31:0]           exc_badvaddr_i,
    output logic [31:0]           data_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  int_req_o,
    output logic                  flush_o,
    output logic [31:0]           redirect_pc_o
);

    logic [7:0]            im_q, im_d;
    logic                  exl_q, exl_d;
    logic                  ie_q, ie_d;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic [NUM_HW_INT-1:0] ip_hw_q;
    logic                  bd_q, bd_d;
    logic [4:0]            code_q, code_d;
    logic [31:0]           epc_q, epc_d;
    logic [31:0]           bva_q, bva_d;

    logic [31:0] count_v, compare_v;
    logic        ti;
    logic [5:0]  hw_ext;
    logic [7:0]  ip;
    logic        status_we, cause_we;

    assign status_we = we_i && (waddr_i == CP0_REG_STATUS);
    assign cause_we  = we_i && (waddr_i == CP0_REG_CAUSE);

`ifdef CP0_TIMER_EN
    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (we_i && (waddr_i == CP0_REG_COUNT)),
        .compare_we_i (we_i && (waddr_i == CP0_REG_COMPARE)),
        .data_i       (data_i),
        .count_o      (count_v),
        .compare_o    (compare_v),
        .ti_o         (ti)
    );
`else
    logic unused_timer_bits;
    assign unused_timer_bits = ^{data_i[31:16], data_i[7:2]};
    assign count_v   = 32'd0;
    assign compare_v = 32'd0;
    assign ti        = 1'b0;
`endif

    // hardware lines sit at IP[2+k]; TI shares IP7 with line 5
    assign hw_ext = 6'(ip_hw_q);
    assign ip     = {hw_ext[5] | ti, hw_ext[4:0], ip_sw_q};

    always_comb begin
        im_d    = im_q;
        exl_d   = exl_q;
        ie_d    = ie_q;
        ip_sw_d = ip_sw_q;
        bd_d    = bd_q;
        code_d  = code_q;
        epc_d   = epc_q;
        bva_d   = bva_q;
        if (status_we) begin
            im_d  = data_i[15:8];
            exl_d = data_i[STATUS_EXL];
            ie_d  = data_i[STATUS_IE];
        end
        if (cause_we) ip_sw_d = data_i[9:8];
        // commit events override the mtc0 write on the fields they own
        if (exc_valid_i) begin
            if (!exl_q) begin
                epc_d = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                bd_d  = exc_bd_i;
            end
            exl_d  = 1'b1;
            code_d = exc_code_i;
            if (exc_code_i == EXC_ADEL || exc_code_i == EXC_ADES)
                bva_d = exc_badvaddr_i;
        end else if (eret_i) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q    <= 8'd0;
            exl_q   <= 1'b0;
            ie_q    <= 1'b0;
            ip_sw_q <= 2'd0;
            ip_hw_q <= '0;
            bd_q    <= 1'b0;
            code_q  <= 5'd0;
            epc_q   <= 32'd0;
            bva_q   <= 32'd0;
        end else begin
            im_q    <= im_d;
            exl_q   <= exl_d;
            ie_q    <= ie_d;
            ip_sw_q <= ip_sw_d;
            ip_hw_q <= hw_int_i;
            bd_q    <= bd_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            bva_q   <= bva_d;
        end
    end

    assign status_o  = STATUS_FIXED | {16'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_o   = {bd_q, ti, 14'd0, ip, 1'b0, code_q, 2'b00};
    assign epc_o     = epc_q;
    assign int_req_o = ie_q && !exl_q && (|(ip & im_q));

    assign flush_o = exc_valid_i || eret_i;

    always_comb begin
        redirect_pc_o = 32'd0;
        if (exc_valid_i)
            redirect_pc_o = status_o[STATUS_BEV] ? EXC_VEC_BOOT : EXC_VEC_NORM;
        else if (eret_i)
            redirect_pc_o = epc_q;
    end

    always_comb begin
        case (raddr_i)
            CP0_REG_BADVADDR: data_o = bva_q;
            CP0_REG_COUNT:    data_o = count_v;
            CP0_REG_COMPARE:  data_o = compare_v;
            CP0_REG_STATUS:   data_o = status_o;
            CP0_REG_CAUSE:    data_o = cause_o;
            CP0_REG_EPC:      data_o = epc_q;
            CP0_REG_PRID:     data_o = PRID_VAL;
            CP0_REG_CONFIG:   data_o = CONFIG_VAL;
            default:          data_o = 32'd0;
        endcase
    end

endmodule
